rgb_stream_fifo: RTL and testbench
==================================

Name: rgb_stream_fifo

Overview:
- Downstream neighbour of the RGB convolution filter stage.
- Takes its valid-only RGB pixel stream (valid/sop/eop, no backpressure) and buffers it in a synchronous FIFO.
- Presents the buffered stream on a ready/valid interface toward the frame writer/DMA.
- On overflow the current frame is truncated and tagged with an error; pixels are then discarded until the next sop, so the output never carries a frame without its eop.

Parameters:
- DATA_WIDTH, 8, width of one colour component.
- ADDR_WIDTH, 9, FIFO address width; DEPTH = 2**ADDR_WIDTH entries; minimum 2.

Ports:
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- data_r_i / data_g_i / data_b_i  in  DATA_WIDTH each  input pixel components.
- valid_i  in  1  input pixel strobe; no backpressure exists on this side.
- sop_i  in  1  first pixel of frame, qualified by valid_i.
- eop_i  in  1  last pixel of frame, qualified by valid_i.
- data_r_o / data_g_o / data_b_o  out  DATA_WIDTH each  output pixel components.
- valid_o  out  1  output word available.
- ready_i  in  1  consumer accepts the word when valid_o && ready_i.
- sop_o  out  1  first-pixel flag of the output word.
- eop_o  out  1  last-pixel flag of the output word.
- err_o  out  1  output word closes a truncated frame (always together with eop_o).
- ovf_o  out  1  sticky; set on any truncation or whole-frame drop.
- level_o  out  ADDR_WIDTH+1  current FIFO occupancy.
- frm_ok_o  out  16  frames completed without error (see optional feature).
- frm_drop_o  out  16  frames truncated or dropped (see optional feature).

Behaviour:
- Storage word: {err, eop, sop, r, g, b}, width 3*DATA_WIDTH+3. Inferred simple dual-port RAM plus a registered output stage (first-word-fall-through).
- Reset values:
  - All outputs 0; level_o 0; state WAIT_SOP.
  - Read and write pointers 0; ovf_o 0; counters 0.
  - Reset mid-frame discards the FIFO contents.
- Latency: a pixel written into the empty FIFO on edge k gives valid_o=1 after edge k+1.
- Throughput: one write and one read per cycle. A simultaneous write and read leaves level unchanged. Output data is stable while valid_o && !ready_i.
- Reserved slot: a write is a "normal" write only while level < DEPTH-1. The last slot is kept for the truncation word.
- States:
  - WAIT_SOP:
    - valid&&!sop: discard.
    - valid&&sop&&level<DEPTH-1: write, go PASS; if eop is also set, write and stay WAIT_SOP (single-pixel frame).
    - valid&&sop&&level>=DEPTH-1: discard, set ovf_o, count a drop, go DROP.
  - PASS:
    - valid&&eop: write, go WAIT_SOP.
    - valid&&!eop&&level<DEPTH-1: normal write.
    - valid&&!eop&&level==DEPTH-1: write the pixel with eop=1, err=1 into the reserved slot, set ovf_o, go DROP.
    - valid&&sop (missing eop): treated as a normal write, no state change.
  - DROP: discard everything until valid&&sop, then apply the WAIT_SOP rules.
- Level accounting: level counts words in RAM plus the output register. A read on the same cycle as the overflow check does not relieve it; the check uses the registered level.
- Full/empty: level never exceeds DEPTH; valid_o=0 when level=0. Pointers wrap modulo DEPTH.

Optional Feature:
- Macro RGB_STREAM_FIFO_STAT_EN.
- Defined: frm_ok_o increments on each accepted output word with eop=1, err=0. frm_drop_o increments on each truncation or whole-frame drop. Both saturate at 0xFFFF and are cleared by reset.
- Not defined: frm_ok_o and frm_drop_o are tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared video package holds:
  - typedef of the FIFO word struct {err, eop, sop, r, g, b};
  - enum for states WAIT_SOP/PASS/DROP;
  - constant for the counter width 16.
- One sub-module: sdp_ram (simple dual-port, registered read, parameterised width/depth). The FSM, pointers and output register stay in the top.

Test Plan (ADDR_WIDTH=4, DEPTH=16):
- Single frame, 10 pixels, ready_i=1 -> 10 words out, in order, sop on 1st, eop on 10th, err=0; first valid_o one cycle after the first write; level_o returns to 0.
- Same 10-pixel frame with ready_i=0 throughout -> level_o=10, valid_o held with word 1 stable; releasing ready_i drains all 10.
- 20-pixel frame, ready_i=0 -> 16 words stored; the 16th carries pixel 16 with eop=1, err=1; pixels 17-20 discarded; ovf_o=1; frm_drop_o=1.
- The previous case followed by a 4-pixel frame after draining -> 4 clean words, frm_ok_o=1, ovf_o still 1.
- Pixels before the first sop after reset, plus a sop arriving with level=15 -> all discarded, DROP entered; the next sop with room is accepted.
- Reset asserted mid-frame with level=7 -> all outputs 0 on the next edge; the following frame passes unmodified.

Source files
------------

// File: rtl/rgb_stream_fifo_pkg.sv
// rtl/rgb_stream_fifo_pkg.sv - shared word flags, FSM states and counter width for the RGB stream FIFO
package rgb_stream_fifo_pkg;

  // Width of the frame statistics counters.
  localparam int CNT_W = 16;

  // Frame tracking states of the write side.
  typedef enum logic [1:0] {
    WAIT_SOP = 2'd0,
    PASS     = 2'd1,
    DROP     = 2'd2
  } fifo_state_t;

  // Control flags stored in front of the pixel components, MSB first: {err, eop, sop}.
  typedef struct packed {
    logic err;
    logic eop;
    logic sop;
  } word_flags_t;

  // Total width of one stored word for a given component width.
  function automatic int word_width(input int data_width);
    return 3 * data_width + $bits(word_flags_t);
  endfunction

endpackage

// File: rtl/rgb_stream_fifo_sdp_ram.sv
// rtl/rgb_stream_fifo_sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
module rgb_stream_fifo_sdp_ram #(
  parameter int WIDTH      = 27,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  i_clk,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [WIDTH-1:0]      o_rd_data
);

  logic [WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
  logic [WIDTH-1:0] r_rd_data;

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port; holds its value while no read is requested.
  always_ff @(posedge i_clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/rgb_stream_fifo.sv
// rtl/rgb_stream_fifo.sv - frame-aware RGB pixel FIFO, valid-only in, ready/valid out; optional stats via RGB_STREAM_FIFO_STAT_EN
module rgb_stream_fifo
  import rgb_stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_r_i,
  input  logic [DATA_WIDTH-1:0] data_g_i,
  input  logic [DATA_WIDTH-1:0] data_b_i,
  input  logic                  valid_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  output logic [DATA_WIDTH-1:0] data_r_o,
  output logic [DATA_WIDTH-1:0] data_g_o,
  output logic [DATA_WIDTH-1:0] data_b_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  sop_o,
  output logic                  eop_o,
  output logic                  err_o,
  output logic                  ovf_o,
  output logic [ADDR_WIDTH:0]   level_o,
  output logic [CNT_W-1:0]      frm_ok_o,
  output logic [CNT_W-1:0]      frm_drop_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int WORD_W = word_width(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] LVL_RSV = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef struct packed {
    word_flags_t           flags;
    logic [DATA_WIDTH-1:0] r;
    logic [DATA_WIDTH-1:0] g;
    logic [DATA_WIDTH-1:0] b;
  } fifo_word_t;

  fifo_state_t           r_state;
  fifo_state_t           w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic [ADDR_WIDTH:0]   w_ram_count;
  logic                  r_out_valid;
  logic                  r_ovf;
  logic                  w_below_rsv;
  logic                  w_wr_en;
  logic                  w_trunc;
  logic                  w_frame_drop;
  logic                  w_pop;
  logic                  w_ram_rd;
  fifo_word_t            w_wr_word;
  fifo_word_t            w_ram_q;
  fifo_word_t            w_out_word;
  logic [WORD_W-1:0]     w_ram_wdata;
  logic [WORD_W-1:0]     w_ram_rdata;

  // The last slot is kept back for the truncation word; the check ignores a same-cycle read.
  assign w_below_rsv = (r_level < LVL_RSV);

  // Level counts the output register as well, so RAM holds level minus that word.
  assign w_ram_count = r_level - (ADDR_WIDTH+1)'(r_out_valid);
  assign w_pop       = r_out_valid & ready_i;
  assign w_ram_rd    = (w_ram_count != '0) & (~r_out_valid | w_pop);

  // Frame tracking state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WAIT_SOP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Write decision per incoming pixel: pass, truncate into the reserved slot, or discard.
  always_comb begin
    w_state_nxt         = r_state;
    w_wr_en             = 1'b0;
    w_trunc             = 1'b0;
    w_frame_drop        = 1'b0;
    w_wr_word.flags.err = 1'b0;
    w_wr_word.flags.eop = eop_i;
    w_wr_word.flags.sop = sop_i;
    w_wr_word.r         = data_r_i;
    w_wr_word.g         = data_g_i;
    w_wr_word.b         = data_b_i;
    if (valid_i) begin
      case (r_state)
        PASS: begin
          if (eop_i) begin
            w_wr_en     = 1'b1;
            w_state_nxt = WAIT_SOP;
          end else if (w_below_rsv) begin
            w_wr_en = 1'b1;
          end else begin
            // Close the frame in the reserved slot so the output never lacks an eop.
            w_wr_en             = 1'b1;
            w_trunc             = 1'b1;
            w_wr_word.flags.eop = 1'b1;
            w_wr_word.flags.err = 1'b1;
            w_state_nxt         = DROP;
          end
        end
        default: begin
          // WAIT_SOP and DROP both wait for a sop and discard anything else.
          if (sop_i) begin
            if (w_below_rsv) begin
              w_wr_en     = 1'b1;
              w_state_nxt = eop_i ? WAIT_SOP : PASS;
            end else begin
              w_frame_drop = 1'b1;
              w_state_nxt  = DROP;
            end
          end
        end
      endcase
    end
  end

  // Pointers, occupancy, output-valid flag and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_ram_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level     <= r_level + (ADDR_WIDTH+1)'(w_wr_en) - (ADDR_WIDTH+1)'(w_pop);
      r_out_valid <= w_ram_rd | (r_out_valid & ~w_pop);
      r_ovf       <= r_ovf | w_trunc | w_frame_drop;
    end
  end

  assign w_ram_wdata = w_wr_word;
  assign w_ram_q     = w_ram_rdata;

  // The RAM read register doubles as the output stage (first-word-fall-through).
  rgb_stream_fifo_sdp_ram #(
    .WIDTH      (WORD_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .i_clk     (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_ram_wdata),
    .i_rd_en   (w_ram_rd),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_ram_rdata)
  );

  // The RAM read register is not reset, so outputs are forced to zero while empty.
  assign w_out_word = r_out_valid ? w_ram_q : '0;

  assign data_r_o = w_out_word.r;
  assign data_g_o = w_out_word.g;
  assign data_b_o = w_out_word.b;
  assign sop_o    = w_out_word.flags.sop;
  assign eop_o    = w_out_word.flags.eop;
  assign err_o    = w_out_word.flags.err;
  assign valid_o  = r_out_valid;
  assign ovf_o    = r_ovf;
  assign level_o  = r_level;

`ifdef RGB_STREAM_FIFO_STAT_EN
  logic [CNT_W-1:0] r_frm_ok;
  logic [CNT_W-1:0] r_frm_drop;
  logic             w_ok_evt;
  logic             w_drop_evt;

  assign w_ok_evt   = w_pop & w_ram_q.flags.eop & ~w_ram_q.flags.err;
  assign w_drop_evt = w_trunc | w_frame_drop;

  // Saturating frame counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frm_ok   <= '0;
      r_frm_drop <= '0;
    end else begin
      if (w_ok_evt && (r_frm_ok != '1)) begin
        r_frm_ok <= r_frm_ok + 1'b1;
      end
      if (w_drop_evt && (r_frm_drop != '1)) begin
        r_frm_drop <= r_frm_drop + 1'b1;
      end
    end
  end

  assign frm_ok_o   = r_frm_ok;
  assign frm_drop_o = r_frm_drop;
`else
  assign frm_ok_o   = '0;
  assign frm_drop_o = '0;
`endif

endmodule

// File: tb/tb_rgb_stream_fifo.sv
// tb/tb_rgb_stream_fifo.sv - self-checking bench for rgb_stream_fifo with a 16-entry FIFO
module tb_rgb_stream_fifo;

  localparam int DW = 8;
  localparam int AW = 4;
`ifdef RGB_STREAM_FIFO_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] data_r_i, data_g_i, data_b_i;
  logic          valid_i, sop_i, eop_i, ready_i;
  logic [DW-1:0] data_r_o, data_g_o, data_b_o;
  logic          valid_o, sop_o, eop_o, err_o, ovf_o;
  logic [AW:0]   level_o;
  logic [15:0]   frm_ok_o, frm_drop_o;

  always #5 clk = ~clk;

  rgb_stream_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .data_r_i(data_r_i), .data_g_i(data_g_i), .data_b_i(data_b_i),
    .valid_i(valid_i), .sop_i(sop_i), .eop_i(eop_i),
    .data_r_o(data_r_o), .data_g_o(data_g_o), .data_b_o(data_b_o),
    .valid_o(valid_o), .ready_i(ready_i),
    .sop_o(sop_o), .eop_o(eop_o), .err_o(err_o), .ovf_o(ovf_o),
    .level_o(level_o), .frm_ok_o(frm_ok_o), .frm_drop_o(frm_drop_o)
  );

  typedef struct {
    int n_pix;
    bit ready;
    int exp_words;
    bit exp_err;
    int exp_level;
    bit exp_ovf;
    int exp_ok;
    int exp_drop;
  } vec_t;

  vec_t        vecs[7];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [26:0] exp_q[$];
  logic [26:0] out_word;
  logic        stall_prev = 1'b0;
  logic [26:0] stall_word;

  assign out_word = {err_o, eop_o, sop_o, data_r_o, data_g_o, data_b_o};

  function automatic logic [23:0] pix(input int f, input int i);
    logic [7:0] r;
    r = 8'((f * 16 + i) & 255);
    return {r, ~r, r ^ 8'h5A};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input int f, input int i, input bit s, input bit e);
    {data_r_i, data_g_i, data_b_i} = pix(f, i);
    valid_i = 1'b1;
    sop_i   = s;
    eop_i   = e;
    tick();
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    sop_i   = 1'b0;
    eop_i   = 1'b0;
    repeat (n) tick();
  endtask

  // Pushes the words the frame should produce, then drives all n pixels back to back.
  task automatic send_frame(input int f, input int n, input int exp_words, input bit exp_err);
    for (int i = 1; i <= n; i++) begin
      if (i <= exp_words) begin
        exp_q.push_back({(exp_err && i == exp_words), (i == exp_words), (i == 1), pix(f, i)});
      end
      drive_pix(f, i, (i == 1), (i == n));
    end
    idle(3);
  endtask

  task automatic wait_drain(input string name);
    int k;
    ready_i = 1'b1;
    k = 0;
    while ((level_o != 0 || valid_o) && k < 200) begin
      tick();
      k++;
    end
    check({name, "_drain_level"}, level_o, 0);
    check({name, "_words_missing"}, exp_q.size(), 0);
  endtask

  task automatic check_stats(input string name, input int ok, input int drop);
    check({name, "_frm_ok"}, frm_ok_o, STAT ? ok : 0);
    check({name, "_frm_drop"}, frm_drop_o, STAT ? drop : 0);
  endtask

  // Output monitor: scoreboard compare on accept, stability check while stalled.
  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", valid_o, 1);
        check("stall_word", out_word, stall_word);
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got %0h expected none", out_word);
        end else begin
          check("out_word", out_word, exp_q.pop_front());
        end
      end
      stall_prev = valid_o && !ready_i;
      stall_word = out_word;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    //            n   rdy words err level ovf ok drop
    vecs[0] = '{10, 1'b1, 10, 1'b0,  0, 1'b0, 1, 0};
    vecs[1] = '{10, 1'b0, 10, 1'b0, 10, 1'b0, 2, 0};
    vecs[2] = '{16, 1'b0, 16, 1'b0, 16, 1'b0, 3, 0};
    vecs[3] = '{20, 1'b0, 16, 1'b1, 16, 1'b1, 3, 1};
    vecs[4] = '{ 4, 1'b1,  4, 1'b0,  0, 1'b1, 4, 1};
    vecs[5] = '{ 1, 1'b1,  1, 1'b0,  0, 1'b1, 5, 1};
    vecs[6] = '{15, 1'b0, 15, 1'b0, 15, 1'b1, 6, 1};

    reset = 1'b1;
    valid_i = 1'b0; sop_i = 1'b0; eop_i = 1'b0; ready_i = 1'b0;
    data_r_i = '0; data_g_i = '0; data_b_i = '0;
    repeat (3) tick();
    check("rst_valid", valid_o, 0);
    check("rst_level", level_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_word", out_word, 0);
    check_stats("rst", 0, 0);
    reset = 1'b0;

    // Pixels before any sop are discarded.
    ready_i = 1'b1;
    drive_pix(1, 1, 1'b0, 1'b0);
    drive_pix(1, 2, 1'b0, 1'b0);
    drive_pix(1, 3, 1'b0, 1'b1);
    idle(3);
    check("presop_level", level_o, 0);
    check("presop_valid", valid_o, 0);

    // First valid_o one edge after the first write.
    exp_q.push_back({1'b0, 1'b0, 1'b1, pix(2, 1)});
    exp_q.push_back({1'b0, 1'b1, 1'b0, pix(2, 2)});
    drive_pix(2, 1, 1'b1, 1'b0);
    check("lat_edge_k", valid_o, 0);
    drive_pix(2, 2, 1'b0, 1'b1);
    check("lat_edge_k1", valid_o, 1);
    idle(3);
    check("lat_level", level_o, 0);

    // A sop arriving at level 15 drops the whole frame.
    ready_i = 1'b0;
    send_frame(3, 15, 15, 1'b0);
    check("fill15_level", level_o, 15);
    send_frame(4, 3, 0, 1'b0);
    check("sopfull_level", level_o, 15);
    check("sopfull_ovf", ovf_o, 1);
    check_stats("sopfull", 1, 1);
    wait_drain("sopfull");
    ready_i = 1'b1;
    send_frame(5, 3, 3, 1'b0);
    wait_drain("after_drop");
    check("after_drop_ovf", ovf_o, 1);
    check_stats("after_drop", 3, 1);

    reset = 1'b1;
    idle(1);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      ready_i = vecs[v].ready;
      send_frame(10 + v, vecs[v].n_pix, vecs[v].exp_words, vecs[v].exp_err);
      check($sformatf("v%0d_level", v), level_o, vecs[v].exp_level);
      if (!vecs[v].ready) begin
        check($sformatf("v%0d_held_valid", v), valid_o, 1);
        check($sformatf("v%0d_held_word", v), out_word, exp_q[0]);
      end
      check($sformatf("v%0d_ovf", v), ovf_o, vecs[v].exp_ovf);
      wait_drain($sformatf("v%0d", v));
      check_stats($sformatf("v%0d", v), vecs[v].exp_ok, vecs[v].exp_drop);
    end

    // Reset in the middle of a frame with seven words buffered.
    ready_i = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      drive_pix(20, i, (i == 1), 1'b0);
    end
    idle(1);
    check("midrst_level_before", level_o, 7);
    reset = 1'b1;
    tick();
    check("midrst_valid", valid_o, 0);
    check("midrst_level", level_o, 0);
    check("midrst_ovf", ovf_o, 0);
    check("midrst_word", out_word, 0);
    check_stats("midrst", 0, 0);
    reset = 1'b0;
    ready_i = 1'b1;
    send_frame(21, 5, 5, 1'b0);
    wait_drain("post_rst");
    check_stats("post_rst", 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
